// File: rtl/seq_pkg.sv
// Shared types for the ROM program sequencer: FSM states, instruction fields.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package seq_pkg;

    localparam int OP_BIT  = 0;
    localparam int IMM_LSB = 1;
    localparam int IMM_MSB = 8;
    localparam int IN_LSB  = 9;
    localparam int OUT_LSB = 11;

    localparam logic [1:0] HALT_SEL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WB,
        FIN
`ifdef SEQ_SINGLE_STEP_EN
        ,
        PAUSE
`endif
    } seq_state_t;

    typedef struct packed {
        logic [1:0] out_sel;
        logic [1:0] in_sel;
        logic [7:0] imm;
        logic       op;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [12:0] w);
        instr_t i;
        i.out_sel = w[OUT_LSB+1:OUT_LSB];
        i.in_sel  = w[IN_LSB+1:IN_LSB];
        i.imm     = w[IMM_MSB:IMM_LSB];
        i.op      = w[OP_BIT];
        return i;
    endfunction

    // Select value 3 has no register behind it and maps to no bit.
    function automatic logic [2:0] onehot3(input logic [1:0] sel);
        logic [2:0] r;
        case (sel)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational decode of the latched instruction into bus enables and
// register write strobes for the current sequencer state.
module seq_decode
    import seq_pkg::*;
(
    input  instr_t     instr,
    input  seq_state_t state,
    output logic [2:0] src_en,
    output logic [7:0] imm,
    output logic       add_oe,
    output logic       mul_oe,
    output logic [2:0] reg_we
);

    logic act;
    logic nop;

    always_comb begin
        act    = (state == EXEC) || (state == WB);
        nop    = (instr.in_sel == HALT_SEL);
        src_en = 3'b000;
        add_oe = 1'b0;
        mul_oe = 1'b0;
        reg_we = 3'b000;
        imm    = instr.imm;
        if (act) begin
            add_oe = instr.op;
            mul_oe = ~instr.op;
            if (!nop) begin
                src_en = onehot3(instr.in_sel);
            end
        end
        if (state == WB && !nop) begin
            reg_we = onehot3(instr.out_sel);
        end
    end

endmodule

// File: rtl/rom_program_sequencer.sv
// Steps a PC through the instruction ROM, FETCH-EXEC-WB per word.
// SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after each WB.
module rom_program_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 13,
    parameter int ROM_LAT    = 2,
    parameter int ALU_LAT    = 1,
    parameter int START_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [INSTR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_oe,
    output logic [2:0]         src_en,
    output logic [7:0]         imm,
    output logic               add_oe,
    output logic               mul_oe,
    output logic [2:0]         reg_we,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_MAX   = '1;
    localparam logic [7:0]        ROM_LAST = 8'(ROM_LAT - 1);
    localparam logic [7:0]        ALU_LAST = 8'(ALU_LAT - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            instr_q, instr_d;
    logic [7:0]        cnt_q, cnt_d;
    seq_state_t        after_wb;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step_q, step_d;
    logic              step_rise;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= PC_START;
            instr_q <= '0;
            cnt_q   <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
`ifdef SEQ_SINGLE_STEP_EN
        step_d    = step;
        step_rise = step & ~step_q;
        after_wb  = PAUSE;
`else
        after_wb  = FETCH;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = PC_START;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == ROM_LAST) begin
                    instr_d = unpack_instr(rom_data[12:0]);
                    cnt_d   = '0;
                    state_d = (instr_d.out_sel == HALT_SEL) ? FIN : EXEC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EXEC: begin
                if (cnt_q == ALU_LAST) begin
                    cnt_d   = '0;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB: begin
                // Last ROM word ends the program instead of wrapping.
                if (pc_q == PC_MAX) begin
                    state_d = FIN;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = after_wb;
                end
            end
            FIN: state_d = IDLE;
`ifdef SEQ_SINGLE_STEP_EN
            PAUSE: begin
                if (step_rise) begin
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_addr = pc_q;
        pc       = pc_q;
        rom_oe   = (state_q == FETCH);
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
    end

    seq_decode u_decode (
        .instr  (instr_q),
        .state  (state_q),
        .src_en (src_en),
        .imm    (imm),
        .add_oe (add_oe),
        .mul_oe (mul_oe),
        .reg_we (reg_we)
    );

endmodule

// File: tb/tb_rom_program_sequencer.sv
// Directed vector bench for rom_program_sequencer with a 1-cycle-registered
// ROM model (data valid two cycles after address, matching ROM_LAT=2).
module tb_rom_program_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [12:0] rom_data;
    logic [7:0]  rom_addr;
    logic        rom_oe;
    logic [2:0]  src_en;
    logic [7:0]  imm;
    logic        add_oe;
    logic        mul_oe;
    logic [2:0]  reg_we;
    logic        busy;
    logic        done;
    logic [7:0]  pc;

    logic [12:0] mem [256];
    logic [12:0] rom_q = 13'h0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= mem[rom_addr];
    assign rom_data = rom_q;

    rom_program_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step     (step),
`endif
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .rom_oe   (rom_oe),
        .src_en   (src_en),
        .imm      (imm),
        .add_oe   (add_oe),
        .mul_oe   (mul_oe),
        .reg_we   (reg_we),
        .busy     (busy),
        .done     (done),
        .pc       (pc)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Structural invariants, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv", int'(($countones(src_en) <= 1) && !(add_oe && mul_oe)
                && ($countones(reg_we) <= 1)
                && (reg_we == 3'b000 || add_oe || mul_oe)
                && !(rom_oe && (add_oe || mul_oe))), 1);
        end
    end

    typedef struct {
        logic [12:0] w0;
        logic [2:0]  src;
        logic        add;
        logic        mul;
        logic [2:0]  we;
        int          we_n;
        int          we_cyc;
        logic [7:0]  imm;
        int          done_cyc;
        int          pc;
    } vec_t;

    vec_t vt [5];

    int         we_n, we_cyc, done_cyc;
    logic [2:0] src_s, we_s;
    logic       add_s, mul_s, done_seen, first_ok, refetch0;
    logic [7:0] imm_s;

    task automatic go(input int max_cyc);
        we_n = 0; we_cyc = 0; done_cyc = 0;
        src_s = 0; we_s = 0; add_s = 0; mul_s = 0; imm_s = 0;
        done_seen = 0; first_ok = 0; refetch0 = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == 1) first_ok = rom_oe && (rom_addr == 8'd0);
            if (c > 2 && rom_oe && rom_addr == 8'd0) refetch0 = 1'b1;
            if (reg_we != 3'b000) begin
                we_n++;
                we_s = reg_we;
                if (we_cyc == 0) we_cyc = c;
            end
            if (add_oe || mul_oe) begin
                src_s |= src_en;
                add_s |= add_oe;
                mul_s |= mul_oe;
                imm_s = imm;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0] = '{13'h0003, 3'b001, 1'b1, 1'b0, 3'b001, 1, 4, 8'h01, 7, 1};
        vt[1] = '{13'h0A04, 3'b010, 1'b0, 1'b1, 3'b010, 1, 4, 8'h02, 7, 1};
        vt[2] = '{13'h0601, 3'b000, 1'b1, 1'b0, 3'b000, 0, 0, 8'h00, 7, 1};
        vt[3] = '{13'h14FE, 3'b100, 1'b0, 1'b1, 3'b100, 1, 4, 8'h7F, 7, 1};
        vt[4] = '{13'h1800, 3'b000, 1'b0, 1'b0, 3'b000, 0, 0, 8'h00, 3, 0};

        for (int i = 0; i < 256; i++) mem[i] = 13'h1800;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_en", {rom_oe, src_en, add_oe, mul_oe, reg_we, done}, 0);
        chk("rst_imm", imm, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            mem[0] = vt[v].w0;
            mem[1] = 13'h1800;
            go(50);
            chk($sformatf("v%0d_done", v), done_seen, 1);
            chk($sformatf("v%0d_done_cyc", v), done_cyc, vt[v].done_cyc);
            chk($sformatf("v%0d_fetch0", v), first_ok, 1);
            chk($sformatf("v%0d_src", v), src_s, vt[v].src);
            chk($sformatf("v%0d_add", v), add_s, vt[v].add);
            chk($sformatf("v%0d_mul", v), mul_s, vt[v].mul);
            chk($sformatf("v%0d_imm", v), imm_s, vt[v].imm);
            chk($sformatf("v%0d_we", v), we_s, vt[v].we);
            chk($sformatf("v%0d_we_n", v), we_n, vt[v].we_n);
            chk($sformatf("v%0d_we_cyc", v), we_cyc, vt[v].we_cyc);
            chk($sformatf("v%0d_pc", v), pc, vt[v].pc);
            chk($sformatf("v%0d_busy", v), busy, 0);
        end

        // Whole ROM without HALT: runs to the last word, never wraps.
        for (int i = 0; i < 256; i++) mem[i] = 13'h0003;
        go(2000);
        chk("full_done", done_seen, 1);
        chk("full_done_cyc", done_cyc, 1025);
        chk("full_we_n", we_n, 256);
        chk("full_refetch0", refetch0, 0);
        chk("full_pc", pc, 255);
        chk("full_busy", busy, 0);

        // Reset during EXEC of instruction 5.
        begin
            bit hit = 0;
            int wb = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 100 && !hit; c++) begin
                if (reg_we != 3'b000) wb++;
                if (pc == 8'd5 && add_oe && reg_we == 3'b000) hit = 1;
                else begin
                    @(posedge clk); #1;
                end
            end
            chk("mid_reach", hit, 1);
            chk("mid_wb_before", wb, 5);
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("mid_outs", {rom_oe, src_en, add_oe, mul_oe, reg_we, done, busy}, 0);
            chk("mid_pc", pc, 0);
            chk("mid_imm", imm, 0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("mid_no_we", {reg_we, busy}, 0);
        end
        mem[1] = 13'h1800;
        go(50);
        chk("rerun_fetch0", first_ok, 1);
        chk("rerun_we_n", we_n, 1);
        chk("rerun_we_cyc", we_cyc, 4);
        chk("rerun_pc", pc, 1);

        // start held high through FIN restarts straight from IDLE.
        begin
            bit seen = 0;
            start = 1'b1;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(posedge clk); #1;
                if (done) seen = 1;
            end
            chk("hold_done", seen, 1);
            @(posedge clk); #1;
            chk("hold_idle", busy, 0);
            @(posedge clk); #1;
            chk("hold_refetch", {rom_oe, rom_addr}, {1'b1, 8'd0});
            start = 1'b0;
            seen = 0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(posedge clk); #1;
                if (done) seen = 1;
            end
            chk("hold_done2", seen, 1);
            @(posedge clk); #1;
        end

`ifdef SEQ_SINGLE_STEP_EN
        begin
            bit got = 0;
            bit stuck = 1;
            mem[0] = 13'h0003;
            mem[1] = 13'h0A04;
            mem[2] = 13'h1800;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (reg_we != 3'b000) got = 1;
                @(posedge clk); #1;
            end
            chk("ss_wb1", got, 1);
            for (int c = 0; c < 4; c++) begin
                if (rom_oe || !busy || reg_we != 3'b000) stuck = 0;
                @(posedge clk); #1;
            end
            chk("ss_pause1", stuck, 1);
            chk("ss_pc1", pc, 1);
            step = 1'b1;
            @(posedge clk); #1;
            chk("ss_fetch", rom_oe, 1);
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (reg_we != 3'b000) got = 1;
                @(posedge clk); #1;
            end
            chk("ss_wb2", got, 1);
            stuck = 1;
            for (int c = 0; c < 6; c++) begin
                if (rom_oe || !busy) stuck = 0;
                @(posedge clk); #1;
            end
            chk("ss_hold_one_adv", stuck, 1);
            step = 1'b0;
            @(posedge clk); #1;
            step = 1'b1;
            @(posedge clk); #1;
            chk("ss_fetch2", rom_oe, 1);
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(posedge clk); #1;
                if (done) got = 1;
            end
            chk("ss_done", got, 1);
            chk("ss_pc", pc, 2);
            step = 1'b0;
            @(posedge clk); #1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
